// File: rtl/bf_ctrl_fsm_param.sv
// Bellman-Ford control sequencer: node/edge/iteration/source counters,
// convergence early-exit, multi-source batches and valid/ack handshakes
// toward the relax and result-write datapaths.
module bf_ctrl_fsm_param #(
  parameter int unsigned NODE_W     = 8,
  parameter int unsigned EDGE_W     = 10,
  parameter int unsigned SRC_W      = 4,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [NODE_W-1:0] cfg_num_nodes,
  input  logic [EDGE_W-1:0] cfg_num_edges,
  input  logic [SRC_W-1:0]  cfg_num_src,
  input  logic              load_done,
  output logic              init_en,
  output logic [NODE_W-1:0] node_idx,
  output logic [SRC_W-1:0]  src_idx,
  output logic              edge_req,
  output logic [EDGE_W-1:0] edge_idx,
  input  logic              edge_ack,
  input  logic              relaxed,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [NODE_W-1:0] iter_count,
  output logic              busy,
  output logic              done,
  output logic              neg_cycle,
  output logic              cfg_err,
  output logic [3:0]        fsm_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_INIT     = 4'd2,
    S_ITER     = 4'd3,
    S_ITER_END = 4'd4,
    S_NEG_CHK  = 4'd5,
    S_NEG_END  = 4'd6,
    S_WRITE    = 4'd7,
    S_NEXT_SRC = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t            r_state;
  logic [NODE_W-1:0] r_num_nodes;
  logic [EDGE_W-1:0] r_num_edges;
  logic [SRC_W-1:0]  r_num_src;
  logic [NODE_W-1:0] r_node;
  logic [EDGE_W-1:0] r_edge;
  logic [SRC_W-1:0]  r_src;
  logic [NODE_W-1:0] r_iter;
  logic              r_changed;
  logic              r_neg_cycle;
  logic              r_cfg_err;

  logic [NODE_W-1:0] w_iter_next;
  logic [SRC_W-1:0]  w_src_next;
  logic              w_last_node;
  logic              w_last_edge;
  logic              w_no_edges;
  logic              w_last_iter;
  logic              w_last_src;

  assign w_iter_next = r_iter + NODE_W'(1);
  assign w_src_next  = r_src + SRC_W'(1);
  assign w_last_node = (r_node == r_num_nodes - NODE_W'(1));
  assign w_last_edge = (r_edge == r_num_edges - EDGE_W'(1));
  assign w_no_edges  = (r_num_edges == '0);
  assign w_last_iter = (w_iter_next == r_num_nodes - NODE_W'(1));
  assign w_last_src  = (w_src_next == r_num_src);

  // Sequencer: state and all counters advance together on handshakes
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_num_nodes <= '0;
      r_num_edges <= '0;
      r_num_src   <= '0;
      r_node      <= '0;
      r_edge      <= '0;
      r_src       <= '0;
      r_iter      <= '0;
      r_changed   <= 1'b0;
      r_neg_cycle <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_nodes <= cfg_num_nodes;
            r_num_edges <= cfg_num_edges;
            r_num_src   <= cfg_num_src;
            r_src       <= '0;
            r_node      <= '0;
            r_edge      <= '0;
            r_iter      <= '0;
            r_changed   <= 1'b0;
            if (cfg_num_nodes == '0 || cfg_num_src == '0) begin
              r_cfg_err <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_state   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (load_done) begin
            r_node  <= '0;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          if (w_last_node) begin
            r_node    <= '0;
            r_iter    <= '0;
            r_edge    <= '0;
            r_changed <= 1'b0;
            r_state   <= (r_num_nodes == NODE_W'(1)) ? S_WRITE : S_ITER;
          end else begin
            r_node <= r_node + NODE_W'(1);
          end
        end
        // Relax passes and the negative-cycle pass share one edge walk
        S_ITER, S_NEG_CHK: begin
          if (w_no_edges) begin
            r_state <= (r_state == S_ITER) ? S_ITER_END : S_NEG_END;
          end else if (edge_ack) begin
            r_changed <= r_changed | relaxed;
            r_edge    <= r_edge + EDGE_W'(1);
            if (w_last_edge)
              r_state <= (r_state == S_ITER) ? S_ITER_END : S_NEG_END;
          end
        end
        S_ITER_END: begin
          // changed/edge are cleared on every exit so the negative-cycle
          // pass starts from a clean flag, not the last relax pass's result
          r_iter    <= w_iter_next;
          r_edge    <= '0;
          r_changed <= 1'b0;
          if (EARLY_EXIT && !r_changed) begin
            r_node  <= '0;
            r_state <= S_WRITE;
          end else if (w_last_iter) begin
            r_state <= S_NEG_CHK;
          end else begin
            r_state <= S_ITER;
          end
        end
        S_NEG_END: begin
          if (r_changed) begin
            r_neg_cycle <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_node  <= '0;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_ack) begin
            if (w_last_node) begin
              r_node  <= '0;
              r_state <= S_NEXT_SRC;
            end else begin
              r_node <= r_node + NODE_W'(1);
            end
          end
        end
        S_NEXT_SRC: begin
          r_src   <= w_src_next;
          r_state <= w_last_src ? S_DONE : S_INIT;
        end
        S_DONE: begin
          if (!start) begin
            r_neg_cycle <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign init_en    = (r_state == S_INIT);
  assign edge_req   = (r_state == S_ITER || r_state == S_NEG_CHK) && !w_no_edges;
  assign wr_req     = (r_state == S_WRITE);
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign node_idx   = r_node;
  assign src_idx    = r_src;
  assign edge_idx   = r_edge;
  assign iter_count = r_iter;
  assign neg_cycle  = r_neg_cycle;
  assign cfg_err    = r_cfg_err;
  assign fsm_state  = r_state;

endmodule

// File: tb/tb_bf_ctrl_fsm_param.sv
// Directed bench for bf_ctrl_fsm_param: one early-exit instance and one
// full-pass instance sharing stimulus, each started by its own start line.
module tb_bf_ctrl_fsm_param;
  localparam int unsigned NW = 8;
  localparam int unsigned EW = 10;
  localparam int unsigned SW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start_a = 1'b0;
  logic          start_b = 1'b0;
  logic [NW-1:0] cfg_num_nodes = '0;
  logic [EW-1:0] cfg_num_edges = '0;
  logic [SW-1:0] cfg_num_src = '0;
  logic          load_done = 1'b0;
  logic          edge_ack = 1'b0;
  logic          relaxed = 1'b0;
  logic          wr_ack = 1'b0;
  logic          sel = 1'b0;

  logic          a_init_en, a_edge_req, a_wr_req, a_busy, a_done, a_neg_cycle, a_cfg_err;
  logic [NW-1:0] a_node_idx, a_iter_count;
  logic [SW-1:0] a_src_idx;
  logic [EW-1:0] a_edge_idx;
  logic [3:0]    a_fsm_state;
  logic          b_init_en, b_edge_req, b_wr_req, b_busy, b_done, b_neg_cycle, b_cfg_err;
  logic [NW-1:0] b_node_idx, b_iter_count;
  logic [SW-1:0] b_src_idx;
  logic [EW-1:0] b_edge_idx;
  logic [3:0]    b_fsm_state;

  logic          m_init_en, m_edge_req, m_wr_req, m_busy, m_done, m_neg_cycle, m_cfg_err;
  logic [NW-1:0] m_node_idx, m_iter_count;
  logic [SW-1:0] m_src_idx;
  logic [EW-1:0] m_edge_idx;
  logic [3:0]    m_fsm_state;

  int errors = 0;
  int checks = 0;
  int passes, negs, wrs, loads, inits;
  logic [11:0] srclog;
  bit wrseen, aborted;

  // 100 MHz-style free-running clock
  always #5 clock = ~clock;

  bf_ctrl_fsm_param #(.NODE_W(NW), .EDGE_W(EW), .SRC_W(SW), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clock(clock), .reset(reset), .start(start_a),
    .cfg_num_nodes(cfg_num_nodes), .cfg_num_edges(cfg_num_edges), .cfg_num_src(cfg_num_src),
    .load_done(load_done), .init_en(a_init_en), .node_idx(a_node_idx), .src_idx(a_src_idx),
    .edge_req(a_edge_req), .edge_idx(a_edge_idx), .edge_ack(edge_ack), .relaxed(relaxed),
    .wr_req(a_wr_req), .wr_ack(wr_ack), .iter_count(a_iter_count), .busy(a_busy),
    .done(a_done), .neg_cycle(a_neg_cycle), .cfg_err(a_cfg_err), .fsm_state(a_fsm_state)
  );

  bf_ctrl_fsm_param #(.NODE_W(NW), .EDGE_W(EW), .SRC_W(SW), .EARLY_EXIT(1'b0)) u_dut_full (
    .clock(clock), .reset(reset), .start(start_b),
    .cfg_num_nodes(cfg_num_nodes), .cfg_num_edges(cfg_num_edges), .cfg_num_src(cfg_num_src),
    .load_done(load_done), .init_en(b_init_en), .node_idx(b_node_idx), .src_idx(b_src_idx),
    .edge_req(b_edge_req), .edge_idx(b_edge_idx), .edge_ack(edge_ack), .relaxed(relaxed),
    .wr_req(b_wr_req), .wr_ack(wr_ack), .iter_count(b_iter_count), .busy(b_busy),
    .done(b_done), .neg_cycle(b_neg_cycle), .cfg_err(b_cfg_err), .fsm_state(b_fsm_state)
  );

  assign m_init_en    = sel ? b_init_en    : a_init_en;
  assign m_edge_req   = sel ? b_edge_req   : a_edge_req;
  assign m_wr_req     = sel ? b_wr_req     : a_wr_req;
  assign m_busy       = sel ? b_busy       : a_busy;
  assign m_done       = sel ? b_done       : a_done;
  assign m_neg_cycle  = sel ? b_neg_cycle  : a_neg_cycle;
  assign m_cfg_err    = sel ? b_cfg_err    : a_cfg_err;
  assign m_node_idx   = sel ? b_node_idx   : a_node_idx;
  assign m_iter_count = sel ? b_iter_count : a_iter_count;
  assign m_src_idx    = sel ? b_src_idx    : a_src_idx;
  assign m_edge_idx   = sel ? b_edge_idx   : a_edge_idx;
  assign m_fsm_state  = sel ? b_fsm_state  : a_fsm_state;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({m_init_en, m_edge_req, m_wr_req, m_busy, m_done, m_neg_cycle, m_cfg_err,
                m_node_idx, m_src_idx, m_edge_idx, m_iter_count, m_fsm_state});
  endfunction

  // Drives one batch run; the responder acks requests and tallies the trace.
  task automatic run(input bit use_b, input int n, input int e, input int s,
                     input bit relax_all, input bit delays, input bit abort2);
    int st, prev, p_src, nexp, eexp, wexp, ewait, wwait, cyc;
    bit fin;
    sel = use_b;
    cfg_num_nodes = NW'(n);
    cfg_num_edges = EW'(e);
    cfg_num_src   = SW'(s);
    passes = 0; negs = 0; wrs = 0; loads = 0; inits = 0;
    srclog = '0; wrseen = 0; aborted = 0;
    prev = 0; p_src = 0; nexp = 0; eexp = 0; wexp = 0; ewait = 0; wwait = 0; cyc = 0;
    fin = 0;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    while (!fin && cyc < 3000) begin
      st = int'(m_fsm_state);
      if (m_done) begin
        fin = 1;
      end else begin
        chk("busy", 64'(m_busy), 64'(st != 0 && st != 9));
        if (st == 1 && prev != 1) loads++;
        if (st == 2 && prev != 2) begin
          srclog = {srclog[7:0], m_src_idx};
          p_src = 0;
          nexp = 0;
        end
        if ((st == 3 || st == 5) && st != prev) eexp = 0;
        if (st == 7 && prev != 7) wexp = 0;
        if (st == 4) begin passes++; p_src++; end
        if (st == 6) negs++;
        if (m_wr_req) wrseen = 1;
        if (m_init_en) begin
          chk("init_node", 64'(m_node_idx), 64'(nexp));
          nexp++;
          inits++;
        end
        if (abort2 && st == 3 && m_edge_idx == EW'(2)) begin
          reset = 1'b0; edge_ack = 1'b0; wr_ack = 1'b0; relaxed = 1'b0;
          load_done = 1'b0; start_a = 1'b0; start_b = 1'b0;
          tick();
          chk("rst_state", 64'(m_fsm_state), 64'(0));
          chk("rst_outs", outs_vec(), 64'(0));
          reset = 1'b1;
          aborted = 1;
          return;
        end
        load_done = (st == 1);
        // stray acks and a high relaxed outside a real ack must be ignored
        edge_ack  = (st == 2 || st == 7);
        wr_ack    = (st == 2 || st == 3);
        relaxed   = 1'b1;
        if (m_edge_req) begin
          if (ewait == 0) begin
            chk("edge_idx", 64'(m_edge_idx), 64'(eexp));
            eexp++;
            edge_ack = 1'b1;
            relaxed  = relax_all || (st == 3 && p_src == 0);
            ewait    = delays ? int'($urandom_range(3, 0)) : 0;
          end else begin
            edge_ack = 1'b0;
            ewait--;
          end
        end
        if (m_wr_req) begin
          if (wwait == 0) begin
            chk("wr_node", 64'(m_node_idx), 64'(wexp));
            wexp++;
            wrs++;
            wr_ack = 1'b1;
            wwait  = delays ? int'($urandom_range(3, 0)) : 0;
          end else begin
            wr_ack = 1'b0;
            wwait--;
          end
        end
      end
      prev = st;
      if (!fin) begin
        tick();
        cyc++;
      end
    end
    chk("done_reached", 64'(fin), 64'(1));
    edge_ack = 1'b0; wr_ack = 1'b0; relaxed = 1'b0; load_done = 1'b0;
  endtask

  task automatic finish_run(input bit exp_neg, input int exp_iter, input int exp_src);
    chk("done", 64'(m_done), 64'(1));
    chk("neg_cycle", 64'(m_neg_cycle), 64'(exp_neg));
    chk("cfg_err", 64'(m_cfg_err), 64'(0));
    chk("iter_count", 64'(m_iter_count), 64'(exp_iter));
    chk("src_at_done", 64'(m_src_idx), 64'(exp_src));
    tick();
    chk("done_hold", 64'(m_fsm_state), 64'(9));
    start_a = 1'b0; start_b = 1'b0;
    tick();
    chk("idle_state", 64'(m_fsm_state), 64'(0));
    chk("neg_clr", 64'(m_neg_cycle), 64'(0));
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) tick();
    sel = 1'b0; #1;
    chk("reset_a_outs", outs_vec(), 64'(0));
    sel = 1'b1; #1;
    chk("reset_b_outs", outs_vec(), 64'(0));
    sel = 1'b0;
    reset = 1'b1;
    tick();

    // early exit: relaxation on pass 1 only converges after pass 2
    run(1'b0, 4, 5, 1, 1'b0, 1'b0, 1'b0);
    chk("t1_passes", 64'(passes), 64'(2));
    chk("t1_negs", 64'(negs), 64'(0));
    chk("t1_wrs", 64'(wrs), 64'(4));
    chk("t1_loads", 64'(loads), 64'(1));
    chk("t1_inits", 64'(inits), 64'(4));
    finish_run(1'b0, 2, 1);

    // no early exit: N-1 passes then one clean negative-cycle pass
    run(1'b1, 4, 5, 1, 1'b0, 1'b0, 1'b0);
    chk("t2_passes", 64'(passes), 64'(3));
    chk("t2_negs", 64'(negs), 64'(1));
    chk("t2_wrs", 64'(wrs), 64'(4));
    finish_run(1'b0, 3, 1);

    // relaxation never stops: negative cycle, no write-out
    run(1'b0, 3, 3, 1, 1'b1, 1'b0, 1'b0);
    chk("t3_passes", 64'(passes), 64'(2));
    chk("t3_negs", 64'(negs), 64'(1));
    chk("t3_wrseen", 64'(wrseen), 64'(0));
    finish_run(1'b1, 2, 0);

    // three sources over a two-node graph, loaded once
    run(1'b0, 2, 2, 3, 1'b0, 1'b0, 1'b0);
    chk("t4_srclog", 64'(srclog), 64'(12'h012));
    chk("t4_loads", 64'(loads), 64'(1));
    chk("t4_passes", 64'(passes), 64'(3));
    chk("t4_negs", 64'(negs), 64'(3));
    chk("t4_wrs", 64'(wrs), 64'(6));
    chk("t4_inits", 64'(inits), 64'(6));
    finish_run(1'b0, 1, 3);

    // random ack delays, reset at edge 2 of pass 1, then a clean rerun
    run(1'b0, 4, 5, 1, 1'b0, 1'b1, 1'b1);
    chk("t5_aborted", 64'(aborted), 64'(1));
    tick();
    run(1'b0, 4, 5, 1, 1'b0, 1'b1, 1'b0);
    chk("t5_passes", 64'(passes), 64'(2));
    chk("t5_negs", 64'(negs), 64'(0));
    chk("t5_wrs", 64'(wrs), 64'(4));
    finish_run(1'b0, 2, 1);

    // illegal configs: N==0, then S==0
    sel = 1'b0;
    cfg_num_nodes = NW'(0); cfg_num_edges = EW'(3); cfg_num_src = SW'(1);
    start_a = 1'b1;
    tick();
    chk("n0_state", 64'(m_fsm_state), 64'(9));
    chk("n0_cfg_err", 64'(m_cfg_err), 64'(1));
    chk("n0_done", 64'(m_done), 64'(1));
    chk("n0_busy", 64'(m_busy), 64'(0));
    tick();
    chk("n0_hold", 64'(m_fsm_state), 64'(9));
    start_a = 1'b0;
    tick();
    chk("n0_idle", 64'(m_fsm_state), 64'(0));
    chk("n0_cfg_clr", 64'(m_cfg_err), 64'(0));
    cfg_num_nodes = NW'(5); cfg_num_src = SW'(0);
    start_a = 1'b1;
    tick();
    chk("s0_state", 64'(m_fsm_state), 64'(9));
    chk("s0_cfg_err", 64'(m_cfg_err), 64'(1));
    start_a = 1'b0;
    tick();
    chk("s0_cfg_clr", 64'(m_cfg_err), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
